// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: latches the instruction and sequences datapath strobes per state.
// Optional retired-instruction counter enabled by defining CU_PERF_CNT_EN.
module multicycle_control_unit #(
  parameter int MEM_WAIT_CYCLES = 0,
  parameter int ALU_CTRL_W      = 4,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instrCode,
  input  logic                  branchTaken,
  output logic                  pcEn,
  output logic [1:0]            pcMuxSel,
  output logic                  regFileWe,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  aluSrcMuxSel,
  output logic [2:0]            RFWDSrcMuxSel,
  output logic                  busWe,
  output logic                  busRe,
  output logic                  illegalInstr
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      instRetired
`endif
);

  localparam int WAIT_W = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, L_EXE, L_MEM, L_WB,
    S_EXE, S_MEM, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       pc_en_q, pc_en_d;
  logic [1:0] pc_mux_q, pc_mux_d;
  logic       rf_we_q, rf_we_d;
  logic [3:0] alu_q, alu_d;
  logic       alu_src_q, alu_src_d;
  logic [2:0] rfwd_q, rfwd_d;
  logic       bus_we_q, bus_we_d;
  logic       bus_re_q, bus_re_d;
  logic       illegal_q, illegal_d;
  logic       op_known;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      FETCH: begin
        ir_d    = instrCode;
        state_d = DECODE;
      end
      DECODE: begin
        case (ir_q[6:0])
          OP_R:     state_d = R_EXE;
          OP_I:     state_d = I_EXE;
          OP_L:     state_d = L_EXE;
          OP_S:     state_d = S_EXE;
          OP_B:     state_d = B_EXE;
          OP_LUI:   state_d = LU_EXE;
          OP_AUIPC: state_d = AU_EXE;
          OP_JAL:   state_d = J_EXE;
          OP_JALR:  state_d = JL_EXE;
          default:  state_d = FETCH;
        endcase
      end
      L_EXE: begin
        state_d = L_MEM;
        wait_d  = '0;
      end
      L_MEM: begin
        if (wait_q == WAIT_LAST) state_d = L_WB;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      S_EXE: begin
        state_d = S_MEM;
        wait_d  = '0;
      end
      S_MEM: begin
        if (wait_q == WAIT_LAST) state_d = FETCH;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs are registered: decode the state being entered so they line up with state_q.
  always_comb begin
    pc_en_d   = 1'b0;
    pc_mux_d  = 2'd0;
    rf_we_d   = 1'b0;
    alu_d     = 4'b0000;
    alu_src_d = 1'b0;
    rfwd_d    = 3'd0;
    bus_we_d  = 1'b0;
    bus_re_d  = 1'b0;
    illegal_d = 1'b0;
    case (ir_d[6:0])
      OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
    case (state_d)
      DECODE: begin
        if (!op_known) begin
          illegal_d = 1'b1;
          pc_en_d   = 1'b1;
        end
      end
      R_EXE: begin
        alu_d   = {ir_d[30], ir_d[14:12]};
        rf_we_d = 1'b1;
        pc_en_d = 1'b1;
      end
      I_EXE: begin
        alu_d     = (ir_d[14:12] == 3'b101) ? {ir_d[30], ir_d[14:12]} : {1'b0, ir_d[14:12]};
        alu_src_d = 1'b1;
        rf_we_d   = 1'b1;
        pc_en_d   = 1'b1;
      end
      L_EXE, S_EXE: alu_src_d = 1'b1;
      L_MEM:        bus_re_d  = 1'b1;
      L_WB: begin
        rf_we_d = 1'b1;
        rfwd_d  = 3'd1;
        pc_en_d = 1'b1;
      end
      S_MEM: begin
        bus_we_d = 1'b1;
        pc_en_d  = (wait_d == WAIT_LAST);
      end
      B_EXE: begin
        alu_d   = {1'b0, ir_d[14:12]};
        pc_en_d = 1'b1;
      end
      LU_EXE: begin
        rf_we_d = 1'b1;
        rfwd_d  = 3'd2;
        pc_en_d = 1'b1;
      end
      AU_EXE: begin
        rf_we_d = 1'b1;
        rfwd_d  = 3'd3;
        pc_en_d = 1'b1;
      end
      J_EXE: begin
        rf_we_d  = 1'b1;
        rfwd_d   = 3'd4;
        pc_mux_d = 2'd1;
        pc_en_d  = 1'b1;
      end
      JL_EXE: begin
        alu_src_d = 1'b1;
        rf_we_d   = 1'b1;
        rfwd_d    = 3'd4;
        pc_mux_d  = 2'd2;
        pc_en_d   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] ret_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      pc_en_q   <= 1'b0;
      pc_mux_q  <= 2'd0;
      rf_we_q   <= 1'b0;
      alu_q     <= 4'b0000;
      alu_src_q <= 1'b0;
      rfwd_q    <= 3'd0;
      bus_we_q  <= 1'b0;
      bus_re_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef CU_PERF_CNT_EN
      ret_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      pc_en_q   <= pc_en_d;
      pc_mux_q  <= pc_mux_d;
      rf_we_q   <= rf_we_d;
      alu_q     <= alu_d;
      alu_src_q <= alu_src_d;
      rfwd_q    <= rfwd_d;
      bus_we_q  <= bus_we_d;
      bus_re_q  <= bus_re_d;
      illegal_q <= illegal_d;
`ifdef CU_PERF_CNT_EN
      if (pc_en_q && !illegal_q) ret_q <= ret_q + CNT_W'(1);
`endif
    end
  end

  // branchTaken arrives from the datapath during B_EXE itself, so it bypasses the register.
  assign pcMuxSel      = (state_q == B_EXE) ? {1'b0, branchTaken} : pc_mux_q;
  assign pcEn          = pc_en_q;
  assign regFileWe     = rf_we_q;
  assign aluControl    = ALU_CTRL_W'(alu_q);
  assign aluSrcMuxSel  = alu_src_q;
  assign RFWDSrcMuxSel = rfwd_q;
  assign busWe         = bus_we_q;
  assign busRe         = bus_re_q;
  assign illegalInstr  = illegal_q;

`ifdef CU_PERF_CNT_EN
  assign instRetired = ret_q;
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};
`else
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], (CNT_W > 0)};
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one DUT with 2 memory wait cycles, one with none.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D293;
  localparam logic [31:0] I_LW    = 32'h0040A283;
  localparam logic [31:0] I_SW    = 32'h0050A423;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  logic clk, reset;
  logic [31:0] instr_a, instr_b;
  logic br_a;

  logic       pcEn_a, rfWe_a, aluSrc_a, busWe_a, busRe_a, ill_a;
  logic [1:0] pcMux_a;
  logic [4:0] alu_a;
  logic [2:0] rfwd_a;
  logic       pcEn_b, rfWe_b, aluSrc_b, busWe_b, busRe_b, ill_b;
  logic [1:0] pcMux_b;
  logic [3:0] alu_b;
  logic [2:0] rfwd_b;
`ifdef CU_PERF_CNT_EN
  logic [1:0] cnt_a, cnt_b;
`endif

  int n_chk = 0;
  int n_err = 0;

  multicycle_control_unit #(.MEM_WAIT_CYCLES(2), .ALU_CTRL_W(5), .CNT_W(2)) u_dut_a (
    .clk(clk), .reset(reset), .instrCode(instr_a), .branchTaken(br_a),
    .pcEn(pcEn_a), .pcMuxSel(pcMux_a), .regFileWe(rfWe_a), .aluControl(alu_a),
    .aluSrcMuxSel(aluSrc_a), .RFWDSrcMuxSel(rfwd_a), .busWe(busWe_a), .busRe(busRe_a),
    .illegalInstr(ill_a)
`ifdef CU_PERF_CNT_EN
    , .instRetired(cnt_a)
`endif
  );

  multicycle_control_unit #(.MEM_WAIT_CYCLES(0), .ALU_CTRL_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .instrCode(instr_b), .branchTaken(1'b0),
    .pcEn(pcEn_b), .pcMuxSel(pcMux_b), .regFileWe(rfWe_b), .aluControl(alu_b),
    .aluSrcMuxSel(aluSrc_b), .RFWDSrcMuxSel(rfwd_b), .busWe(busWe_b), .busRe(busRe_b),
    .illegalInstr(ill_b)
`ifdef CU_PERF_CNT_EN
    , .instRetired(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    instr_a = 32'h0;
    instr_b = I_SW;
    br_a    = 1'b0;
    cyc(2);
    chk("rst_pcEn",   32'(pcEn_a),  0);
    chk("rst_rfWe",   32'(rfWe_a),  0);
    chk("rst_alu",    32'(alu_a),   0);
    chk("rst_rfwd",   32'(rfwd_a),  0);
    chk("rst_busRe",  32'(busRe_a), 0);
    chk("rst_busWe",  32'(busWe_a), 0);
    chk("rst_ill",    32'(ill_a),   0);
    chk("rst_pcMux",  32'(pcMux_a), 0);
`ifdef CU_PERF_CNT_EN
    chk("rst_cnt",    32'(cnt_a),   0);
`endif

    // Store with no wait cycles on DUT B: busWe and pcEn together in cycle 4.
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sw_c%0d_rfWe", c),  32'(rfWe_b),  0);
      chk($sformatf("sw_c%0d_busWe", c), 32'(busWe_b), (c == 4) ? 1 : 0);
      chk($sformatf("sw_c%0d_pcEn", c),  32'(pcEn_b),  (c == 4) ? 1 : 0);
      if (c == 3) chk("sw_exe_aluSrc", 32'(aluSrc_b), 1);
      cyc(1);
    end
    chk("sw_after_busWe", 32'(busWe_b), 0);

    // Load on DUT A, reset asserted mid L_MEM.
    instr_a = I_LW;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    chk("lmem_busRe_pre", 32'(busRe_a), 1);
    #2 reset = 1'b1;
    #1 chk("lmem_busRe_async", 32'(busRe_a), 0);
    chk("lmem_pcEn_async", 32'(pcEn_a), 0);
    instr_a = I_ADD;
    cyc(1);
    reset = 1'b0;
    chk("add_c1_rfWe", 32'(rfWe_a), 0);
    cyc(1);
    chk("add_c2_pcEn", 32'(pcEn_a), 0);
    cyc(1);
    chk("add_alu",    32'(alu_a),    0);
    chk("add_rfWe",   32'(rfWe_a),   1);
    chk("add_rfwd",   32'(rfwd_a),   0);
    chk("add_pcEn",   32'(pcEn_a),   1);
    chk("add_aluSrc", 32'(aluSrc_a), 0);
    chk("add_busRe",  32'(busRe_a),  0);
    chk("add_busWe",  32'(busWe_a),  0);
    chk("add_pcMux",  32'(pcMux_a),  0);
    cyc(1);
    chk("add_fetch_pcEn", 32'(pcEn_a), 0);

    instr_a = I_SRAI;
    cyc(2);
    chk("srai_alu",    32'(alu_a),    32'h0D);
    chk("srai_aluSrc", 32'(aluSrc_a), 1);
    chk("srai_rfWe",   32'(rfWe_a),   1);
    chk("srai_pcEn",   32'(pcEn_a),   1);
    cyc(1);

    // Load with 2 wait cycles; instrCode is trashed after FETCH.
    instr_a = I_LW;
    cyc(1);
    instr_a = 32'hFFFF_FFFF;
    cyc(1);
    chk("lw_exe_aluSrc", 32'(aluSrc_a), 1);
    chk("lw_exe_alu",    32'(alu_a),    0);
    chk("lw_exe_busRe",  32'(busRe_a),  0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk($sformatf("lw_mem%0d_busRe", i), 32'(busRe_a), 1);
      chk($sformatf("lw_mem%0d_pcEn", i),  32'(pcEn_a),  0);
    end
    cyc(1);
    chk("lw_wb_busRe", 32'(busRe_a), 0);
    chk("lw_wb_rfWe",  32'(rfWe_a),  1);
    chk("lw_wb_rfwd",  32'(rfwd_a),  1);
    chk("lw_wb_pcEn",  32'(pcEn_a),  1);
    cyc(1);
    chk("lw_fetch_pcEn", 32'(pcEn_a), 0);
`ifdef CU_PERF_CNT_EN
    chk("cnt_after_lw", 32'(cnt_a), 3);
`endif

    instr_a = I_BEQ;
    br_a = 1'b1;
    cyc(2);
    chk("beq_t_pcMux", 32'(pcMux_a), 1);
    chk("beq_t_pcEn",  32'(pcEn_a),  1);
    chk("beq_t_rfWe",  32'(rfWe_a),  0);
    cyc(1);
`ifdef CU_PERF_CNT_EN
    chk("cnt_wrap_beq", 32'(cnt_a), 0);
`endif
    br_a = 1'b0;
    cyc(2);
    chk("beq_n_pcMux", 32'(pcMux_a), 0);
    chk("beq_n_pcEn",  32'(pcEn_a),  1);
    chk("beq_n_rfWe",  32'(rfWe_a),  0);
    cyc(1);

    instr_a = I_LUI;
    cyc(2);
    chk("lui_rfwd", 32'(rfwd_a), 2);
    chk("lui_rfWe", 32'(rfWe_a), 1);
    chk("lui_pcEn", 32'(pcEn_a), 1);
    cyc(1);
    instr_a = I_AUIPC;
    cyc(2);
    chk("auipc_rfwd", 32'(rfwd_a), 3);
    chk("auipc_rfWe", 32'(rfWe_a), 1);
    chk("auipc_pcEn", 32'(pcEn_a), 1);
    cyc(1);
`ifdef CU_PERF_CNT_EN
    chk("cnt_before_bad", 32'(cnt_a), 3);
`endif

    instr_a = I_BAD;
    cyc(1);
    chk("bad_ill",   32'(ill_a),   1);
    chk("bad_pcEn",  32'(pcEn_a),  1);
    chk("bad_pcMux", 32'(pcMux_a), 0);
    cyc(1);
    chk("bad_ill_drop", 32'(ill_a), 0);
`ifdef CU_PERF_CNT_EN
    chk("cnt_after_bad", 32'(cnt_a), 3);
`endif

    instr_a = I_JALR;
    cyc(2);
    chk("jalr_pcMux",  32'(pcMux_a),  2);
    chk("jalr_rfwd",   32'(rfwd_a),   4);
    chk("jalr_aluSrc", 32'(aluSrc_a), 1);
    chk("jalr_rfWe",   32'(rfWe_a),   1);
    chk("jalr_pcEn",   32'(pcEn_a),   1);
    cyc(1);
`ifdef CU_PERF_CNT_EN
    chk("cnt_wrap_jalr", 32'(cnt_a), 0);
`endif

    instr_a = I_JAL;
    cyc(2);
    chk("jal_pcMux",  32'(pcMux_a),  1);
    chk("jal_rfwd",   32'(rfwd_a),   4);
    chk("jal_aluSrc", 32'(aluSrc_a), 0);
    chk("jal_pcEn",   32'(pcEn_a),   1);
    cyc(1);
    chk("jal_fetch_pcEn", 32'(pcEn_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
